// File: rtl/pico_ctrl_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pico_pkg
// Brief   : Shared stage encoding, function-field bit map and wait decode
// Revision: 1.0
// ============================================================================
package pico_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    WAIT   = 3'd4
  } stage_t;

  localparam int F_USEA   = 0;
  localparam int F_SELSW  = 1;
  localparam int F_SELIMM = 2;
  localparam int F_USEMUL = 3;
  localparam int F_REGW   = 4;
  localparam int F_SELREG = 5;

  // A register-select immediate is the encoding reserved for the wait instruction.
  function automatic logic is_wait(input logic [5:0] func);
    return func[F_SELREG] & func[F_SELIMM];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pico_ctrl_seq_sync_bit.sv
`default_nettype none
// ============================================================================
// Module  : sync_bit
// Brief   : SYNC-stage single-bit synchroniser, async active-low clear
// Revision: 1.0
// ============================================================================
module sync_bit #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC-1:0] r_sync;

  generate
    if (SYNC == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '0;
        else        r_sync <= i_async;
      end
    end else begin : g_chain
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '0;
        else        r_sync <= {r_sync[SYNC-2:0], i_async};
      end
    end
  endgenerate

  assign o_sync = r_sync[SYNC-1];

endmodule
`default_nettype wire

// File: rtl/pico_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module  : pico_ctrl_seq
// Brief   : picoMips multi-cycle control: IR, stage sequencer, handshake wait
// Revision: 1.0
// ============================================================================
module pico_ctrl_seq #(
  parameter int IW   = 12,
  parameter int OPW  = 6,
  parameter int DW   = 8,
  parameter int SYNC = 2,
  parameter int WCW  = 8
) (
  input  logic           Clock,
  input  logic           nReset,
  input  logic [IW-1:0]  Instruction,
  input  logic           Handshake,
  output logic [DW-1:0]  Immediate,
  output logic [1:0]     Stage,
  output logic           PCEn,
  output logic           Waiting,
  output logic           RegWrite,
  output logic           ACCWE,
  output logic           RegAddr,
  output logic           SelImm,
  output logic           SelSW,
  output logic           UseMul,
  output logic           UseA,
  output logic           SelReg,
  output logic [WCW-1:0] WaitCount
);

  import pico_pkg::*;

  localparam int             IMW       = IW - OPW;
  localparam logic [WCW-1:0] c_cnt_max = '1;

  stage_t         r_state;
  stage_t         w_next;
  logic [IW-1:0]  r_ir;
  logic [WCW-1:0] r_wait_cnt;
  logic [OPW-1:0] w_func;
  logic           w_is_wait;
  logic           w_hei;
  logic           w_hs_s;

  sync_bit #(
    .SYNC(SYNC)
  ) u_hs_sync (
    .clk    (Clock),
    .rst_n  (nReset),
    .i_async(Handshake),
    .o_sync (w_hs_s)
  );

  assign w_func    = r_ir[IW-1 -: OPW];
  assign w_is_wait = is_wait(w_func[5:0]);
  assign w_hei     = r_ir[0];

  // Selects come straight from IR so they cannot glitch on stage changes.
  assign UseA    = w_func[F_USEA];
  assign SelSW   = w_func[F_SELSW];
  assign SelImm  = w_func[F_SELIMM];
  assign UseMul  = w_func[F_USEMUL];
  assign SelReg  = w_func[F_SELREG];
  assign RegAddr = r_ir[0];

  generate
    if (IMW >= DW) begin : g_imm_trunc
      assign Immediate = r_ir[DW-1:0];
    end else begin : g_imm_sext
      assign Immediate = {{(DW-IMW){r_ir[IMW-1]}}, r_ir[IMW-1:0]};
    end
  endgenerate

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) r_state <= FETCH;
    else         r_state <= w_next;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)               r_ir <= '0;
    else if (r_state == FETCH) r_ir <= Instruction;
  end

  // Counter holds outside WAIT so the last wait duration stays observable.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_wait_cnt <= '0;
    end else if (r_state == DECODE && w_is_wait) begin
      r_wait_cnt <= '0;
    end else if (r_state == WAIT && w_hs_s == w_hei && r_wait_cnt != c_cnt_max) begin
      r_wait_cnt <= r_wait_cnt + WCW'(1);
    end
  end

  assign WaitCount = r_wait_cnt;

  always_comb begin
    w_next   = r_state;
    Stage    = 2'd0;
    PCEn     = 1'b0;
    Waiting  = 1'b0;
    RegWrite = 1'b0;
    ACCWE    = 1'b0;
    case (r_state)
      FETCH: begin
        Stage  = 2'd0;
        w_next = DECODE;
      end
      DECODE: begin
        Stage  = 2'd1;
        w_next = w_is_wait ? WAIT : EXEC;
      end
      WAIT: begin
        Stage   = 2'd1;
        Waiting = 1'b1;
        if (w_hs_s != w_hei) w_next = EXEC;
      end
      EXEC: begin
        Stage  = 2'd2;
        ACCWE  = ~w_is_wait;
        w_next = WB;
      end
      WB: begin
        Stage    = 2'd3;
        PCEn     = 1'b1;
        RegWrite = w_func[F_REGW];
        w_next   = FETCH;
      end
      default: begin
        w_next = FETCH;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pico_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_pico_ctrl_seq
// Brief   : Self-checking bench for pico_ctrl_seq against a behavioural model
// Revision: 1.0
// ============================================================================
module tb_pico_ctrl_seq;

  localparam int SYNC = 2;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic [11:0] Instruction = '0;
  logic        Handshake = 1'b0;

  logic [7:0] Immediate, WaitCount, Immediate4;
  logic [3:0] WaitCount4;
  logic [1:0] Stage, Stage4;
  logic PCEn, Waiting, RegWrite, ACCWE, RegAddr, SelImm, SelSW, UseMul, UseA, SelReg;
  logic PCEn4, Waiting4, RegWrite4, ACCWE4, RegAddr4, SelImm4, SelSW4, UseMul4, UseA4, SelReg4;

  pico_ctrl_seq #(.IW(12), .OPW(6), .DW(8), .SYNC(SYNC), .WCW(8)) dut (
    .Clock(Clock), .nReset(nReset), .Instruction(Instruction), .Handshake(Handshake),
    .Immediate(Immediate), .Stage(Stage), .PCEn(PCEn), .Waiting(Waiting),
    .RegWrite(RegWrite), .ACCWE(ACCWE), .RegAddr(RegAddr), .SelImm(SelImm),
    .SelSW(SelSW), .UseMul(UseMul), .UseA(UseA), .SelReg(SelReg), .WaitCount(WaitCount)
  );

  pico_ctrl_seq #(.IW(12), .OPW(6), .DW(8), .SYNC(SYNC), .WCW(4)) dut4 (
    .Clock(Clock), .nReset(nReset), .Instruction(Instruction), .Handshake(Handshake),
    .Immediate(Immediate4), .Stage(Stage4), .PCEn(PCEn4), .Waiting(Waiting4),
    .RegWrite(RegWrite4), .ACCWE(ACCWE4), .RegAddr(RegAddr4), .SelImm(SelImm4),
    .SelSW(SelSW4), .UseMul(UseMul4), .UseA(UseA4), .SelReg(SelReg4), .WaitCount(WaitCount4)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: phase 0..3 = FETCH/DECODE/EXEC/WB, 4 = waiting on handshake.
  logic [11:0] m_ir;
  int          m_stage;
  int          m_cnt8, m_cnt4;
  logic        m_hist[$];

  function automatic void model_reset();
    m_ir = '0; m_stage = 0; m_cnt8 = 0; m_cnt4 = 0;
    m_hist = {};
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
  endfunction

  function automatic void model_edge();
    logic seen = m_hist[SYNC-1];
    logic is_w = m_ir[11] & m_ir[8];
    m_hist.push_front(Handshake);
    void'(m_hist.pop_back());
    case (m_stage)
      0: begin m_ir = Instruction; m_stage = 1; end
      1: begin
        if (is_w) begin m_stage = 4; m_cnt8 = 0; m_cnt4 = 0; end
        else m_stage = 2;
      end
      4: begin
        if (seen == m_ir[0]) begin
          if (m_cnt8 < 255) m_cnt8++;
          if (m_cnt4 < 15) m_cnt4++;
        end else m_stage = 2;
      end
      2: m_stage = 3;
      default: m_stage = 0;
    endcase
  endfunction

  function automatic logic [27:0] exp_vec();
    logic [5:0] f = m_ir[11:6];
    logic w = f[5] & f[2];
    logic [1:0] st = (m_stage == 4) ? 2'd1 : 2'(m_stage);
    logic [7:0] imm = {{2{m_ir[5]}}, m_ir[5:0]};
    return {st, m_stage == 3, m_stage == 4, (m_stage == 3) & f[4], (m_stage == 2) & ~w,
            m_ir[0], f[2], f[1], f[3], f[0], f[5], imm, 8'(m_cnt8)};
  endfunction

  function automatic logic [27:0] dut_vec();
    return {Stage, PCEn, Waiting, RegWrite, ACCWE, RegAddr, SelImm, SelSW, UseMul, UseA,
            SelReg, Immediate, WaitCount};
  endfunction

  task automatic step(input logic hs, input logic [11:0] instr);
    Handshake = hs;
    Instruction = instr;
    @(posedge Clock);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic align_fetch(input logic hs);
    for (int i = 0; i < 300 && m_stage != 0; i++) step(hs, 12'h000);
  endtask

  task automatic test_reset();
    nReset = 1'b0; Instruction = 12'hFFF; Handshake = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      n_checks++;
      if (dut_vec() !== 28'd0 || WaitCount4 !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %h/%h, want 0/0", i, dut_vec(), WaitCount4);
      end
    end
    @(negedge Clock);
    Instruction = 12'b010000_000011; Handshake = 1'b0;
    nReset = 1'b1;
    #1;
    n_checks++;
    if (Stage !== 2'd0) begin
      n_fail++; $display("FAIL release_stage: got %0d, want 0", Stage);
    end
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 12'b010000_000011);
      n_checks++;
      if (Stage !== 2'(i % 4) || PCEn !== (i == 3)) begin
        n_fail++;
        $display("FAIL release_sequence step %0d: stage=%0d pcen=%b, want stage=%0d pcen=%b",
                 i, Stage, PCEn, i % 4, i == 3);
      end
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL release_model step %0d: got %h, want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_decode();
    logic [11:0] instr[3] = '{12'b010000_000011, 12'b000100_100000, 12'b001010_011111};
    logic [7:0]  imm[3]   = '{8'h03, 8'hE0, 8'h1F};
    logic [4:0]  sel[3]   = '{5'b00000, 5'b00100, 5'b01010}; // SelReg,UseMul,SelImm,SelSW,UseA
    for (int k = 0; k < 3; k++) begin
      int n_rw = 0, n_acc = 0, n_wait = 0;
      align_fetch(1'b0);
      for (int i = 0; i < 4; i++) begin
        step(1'b0, instr[k]);
        n_rw   += (RegWrite === 1'b1) ? 1 : 0;
        n_acc  += (ACCWE === 1'b1) ? 1 : 0;
        n_wait += (Waiting === 1'b1) ? 1 : 0;
        if (RegWrite === 1'b1 && Stage !== 2'd3) begin
          n_fail++; $display("FAIL decode_regwrite_stage instr %0d: stage=%0d, want 3", k, Stage);
        end
        if (ACCWE === 1'b1 && Stage !== 2'd2) begin
          n_fail++; $display("FAIL decode_accwe_stage instr %0d: stage=%0d, want 2", k, Stage);
        end
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL decode_model instr %0d step %0d: got %h, want %h", k, i, dut_vec(), exp_vec());
        end
        if (i == 0) begin
          n_checks++;
          if (Immediate !== imm[k] || {SelReg, UseMul, SelImm, SelSW, UseA} !== sel[k]) begin
            n_fail++;
            $display("FAIL decode_fields instr %0d: imm=%h sel=%b, want imm=%h sel=%b",
                     k, Immediate, {SelReg, UseMul, SelImm, SelSW, UseA}, imm[k], sel[k]);
          end
        end
      end
      n_checks++;
      if (n_rw != (k == 0 ? 1 : 0) || n_acc != 1 || n_wait != 0) begin
        n_fail++;
        $display("FAIL decode_pulses instr %0d: regw=%0d accwe=%0d wait=%0d, want %0d/1/0",
                 k, n_rw, n_acc, n_wait, k == 0 ? 1 : 0);
      end
    end
  endtask

  task automatic test_wait();
    int lat = 0, n_pc = 0, n_wait = 0;
    logic [11:0] wi = 12'b100100_000001;
    align_fetch(1'b1);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, wi);
      n_pc += PCEn ? 1 : 0; n_wait += Waiting ? 1 : 0;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL wait_hold step %0d: got %h, want %h", i, dut_vec(), exp_vec());
      end
    end
    while (lat < 20) begin
      step(1'b0, wi);
      lat++;
      if (Stage === 2'd2) break;
      n_wait += Waiting ? 1 : 0;
    end
    n_checks++;
    if (lat != SYNC + 1) begin
      n_fail++; $display("FAIL wait_exit_latency: got %0d cycles, want %0d", lat, SYNC + 1);
    end
    n_checks++;
    if (ACCWE !== 1'b0 || WaitCount !== 8'(m_cnt8) || n_wait != m_cnt8 + 1) begin
      n_fail++;
      $display("FAIL wait_exec: accwe=%b count=%0d waitcycles=%0d, want 0/%0d/%0d",
               ACCWE, WaitCount, n_wait, m_cnt8, m_cnt8 + 1);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 12'h000);
      n_pc += PCEn ? 1 : 0;
    end
    n_checks++;
    if (n_pc != 1 || Stage !== 2'd0) begin
      n_fail++; $display("FAIL wait_pcen: pulses=%0d stage=%0d, want 1/0", n_pc, Stage);
    end
  endtask

  task automatic test_wait_saturation();
    int guard = 0;
    align_fetch(1'b1);
    for (int i = 0; i < 42; i++) step(1'b1, 12'b100100_000001);
    while (Stage !== 2'd2 && guard < 20) begin step(1'b0, 12'h000); guard++; end
    n_checks++;
    if (Stage !== 2'd2 || WaitCount4 !== 4'd15 || WaitCount !== 8'(m_cnt8)) begin
      n_fail++;
      $display("FAIL wait_saturate: stage=%0d wc4=%0d wc8=%0d, want 2/15/%0d", Stage, WaitCount4, WaitCount, m_cnt8);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 12'b000100_100000);
    n_checks++;
    if (WaitCount4 !== 4'd15 || WaitCount !== 8'(m_cnt8) || m_cnt8 < 40) begin
      n_fail++; $display("FAIL wait_hold_after_exit: wc4=%0d wc8=%0d, want 15/%0d", WaitCount4, WaitCount, m_cnt8);
    end
  endtask

  task automatic test_wait_immediate_exit();
    int n_wait = 0;
    align_fetch(1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 12'h000);
    align_fetch(1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 12'b100100_000001);
      n_wait += Waiting ? 1 : 0;
    end
    n_checks++;
    if (n_wait != 1 || WaitCount !== 8'd0 || WaitCount4 !== 4'd0) begin
      n_fail++; $display("FAIL wait_immediate: waitcycles=%0d count=%0d, want 1/0", n_wait, WaitCount);
    end
  endtask

  task automatic test_reset_mid_wait();
    int guard = 0;
    align_fetch(1'b1);
    while (!(m_stage == 4 && m_cnt8 == 5) && guard < 30) begin step(1'b1, 12'b100100_000001); guard++; end
    n_checks++;
    if (WaitCount !== 8'd5 || Waiting !== 1'b1) begin
      n_fail++; $display("FAIL midwait_setup: count=%0d waiting=%b, want 5/1", WaitCount, Waiting);
    end
    #2 nReset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec() !== 28'd0 || WaitCount4 !== 4'd0) begin
      n_fail++; $display("FAIL midwait_reset: got %h/%h, want 0/0", dut_vec(), WaitCount4);
    end
    @(negedge Clock);
    nReset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 12'b000100_100000);
      n_checks++;
      if (dut_vec() !== exp_vec() || PCEn !== (i == 3)) begin
        n_fail++; $display("FAIL after_reset step %0d: got %h pcen=%b, want %h", i, dut_vec(), PCEn, exp_vec());
      end
    end
    n_checks++;
    if (Immediate !== 8'hE0) begin
      n_fail++; $display("FAIL after_reset_resample: imm=%h, want e0", Immediate);
    end
  endtask

  task automatic test_random();
    logic hs = 1'b0;
    logic [11:0] ins;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) hs = ~hs;
      ins = 12'($urandom);
      step(hs, ins);
      n_checks++;
      if (dut_vec() !== exp_vec() || WaitCount4 !== 4'(m_cnt4)) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h/%0d, want %h/%0d", cyc, dut_vec(), WaitCount4, exp_vec(), m_cnt4);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_decode();
    test_wait();
    test_wait_saturation();
    test_wait_immediate_exit();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
